// File: rtl/wb_select_unit_pkg.sv
// Shared types and constants for the MIPS write-back select unit.
// Package mips_wb_pkg: FSM state encoding, source select codes, default constant.
package mips_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int SEL_ALUOUT   = 0;
    localparam int SEL_LOADSIZE = 1;
    localparam int SEL_HI       = 2;
    localparam int SEL_LO       = 3;
    localparam int SEL_SHIFTREG = 4;
    localparam int SEL_CONST    = 5;
    localparam int SEL_SHL16    = 6;
    localparam int SEL_RT       = 7;
    localparam int SEL_SIGNEXT  = 8;

    localparam int CONST_VAL_DEFAULT = 277;

endpackage

// File: rtl/wb_select_unit_src_mux.sv
// Combinational indexed source select for the write-back unit.
// The constant code and out-of-range codes override the slot lookup and are "direct" (always valid).
module wb_src_mux #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_SRC   = 9,
    parameter int                SEL_W     = 4,
    parameter int                CONST_SEL = 5,
    parameter logic [DATA_W-1:0] CONST_VAL = '0
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [DATA_W-1:0]         data,
    output logic                      valid,
    output logic                      direct,
    output logic                      range_err
);

    always_comb begin
        data      = '0;
        valid     = 1'b0;
        direct    = 1'b0;
        range_err = 1'b0;
        if (int'(sel) >= NUM_SRC) begin
            // Out-of-range selects write zero and flag the error.
            valid     = 1'b1;
            direct    = 1'b1;
            range_err = 1'b1;
        end else if (int'(sel) == CONST_SEL) begin
            data   = CONST_VAL;
            valid  = 1'b1;
            direct = 1'b1;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (int'(sel) == i) begin
                    data  = src_data[i*DATA_W +: DATA_W];
                    valid = src_valid[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_select_unit.sv
// Registered, handshaked write-back source select: accept a request, wait for its source, issue one write.
// Optional macro WB_TIMEOUT_EN bounds the WAIT state to TIMEOUT cycles.
module wb_select_unit
    import mips_wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 9,
    parameter int SEL_W      = 4,
    parameter int REG_ADDR_W = 5,
    parameter int CONST_SEL  = SEL_CONST,
    parameter int CONST_VAL  = CONST_VAL_DEFAULT,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [REG_ADDR_W-1:0]     dest_reg,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic                      wb_en,
    output logic [REG_ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      sel_err,
    output logic                      busy,
    output state_e                    dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so at most one request is in flight.

    if (TIMEOUT < 1 || (2**SEL_W) < NUM_SRC) begin : g_param_check
        $error("wb_select_unit: TIMEOUT must be >= 1 and 2**SEL_W >= NUM_SRC");
    end

    state_e                  state;
    state_e                  state_next;
    logic [SEL_W-1:0]        sel_q;
    logic [REG_ADDR_W-1:0]   dest_q;
    logic [SEL_W-1:0]        mux_sel;
    logic [REG_ADDR_W-1:0]   dest_cur;
    logic [DATA_W-1:0]       mux_data;
    logic                    mux_valid;
    logic                    mux_direct;
    logic                    mux_range_err;
    logic                    accept;
    logic                    capture;
    logic                    capture_err;
    logic                    timed_out;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign accept    = req_valid && req_ready;

    // Direct selects resolve on the accept edge, before sel_q/dest_q exist.
    assign mux_sel  = (state == IDLE) ? sel      : sel_q;
    assign dest_cur = (state == IDLE) ? dest_reg : dest_q;

    wb_src_mux #(
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .SEL_W     (SEL_W),
        .CONST_SEL (CONST_SEL),
        .CONST_VAL (DATA_W'(CONST_VAL))
    ) u_src_mux (
        .sel       (mux_sel),
        .src_data  (src_data),
        .src_valid (src_valid),
        .data      (mux_data),
        .valid     (mux_valid),
        .direct    (mux_direct),
        .range_err (mux_range_err)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timed_out = (state == WAIT) && !mux_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        capture_err = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mux_direct) begin
                        state_next  = WRITE;
                        capture     = 1'b1;
                        capture_err = mux_range_err;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mux_valid) begin
                    state_next = WRITE;
                    capture    = 1'b1;
                end else if (timed_out) begin
                    state_next  = WRITE;
                    capture     = 1'b1;
                    capture_err = 1'b1;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are loaded on the edge entering WRITE, so they line up with that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel_q   <= '0;
            dest_q  <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            sel_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel_q  <= sel;
                dest_q <= dest_reg;
            end
            wb_en   <= capture && !timed_out && (dest_cur != '0);
            sel_err <= capture && capture_err;
            if (capture) begin
                wb_addr <= dest_cur;
                wb_data <= timed_out ? '0 : mux_data;
            end
        end
    end

endmodule

// File: doc/wb_select_unit.md
Name: wb_select_unit

Overview:
- Registered, handshaked successor to the write-back source mux in the multicycle MIPS datapath.
- Accepts one write-back request: a source select plus a destination register.
- Waits until the selected source reports its data valid. This covers multi-cycle sources such as Hi/Lo after mult/div.
- Then issues a single-cycle register-file write with registered address and data.

Parameters:
- DATA_W, 32: width of every source and of wb_data.
- NUM_SRC, 9: number of indexed source slots; sel codes 0..NUM_SRC-1 address slots.
- SEL_W, 4: select width; must satisfy 2**SEL_W >= NUM_SRC.
- REG_ADDR_W, 5: register-file address width.
- CONST_SEL, 5: select code that returns CONST_VAL; slot CONST_SEL of src_data is ignored.
- CONST_VAL, 277: constant written when sel == CONST_SEL.
- TIMEOUT, 16: WAIT-state cycle limit; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  write-back request present.
- req_ready  out  1  unit can accept a request; equals (state == IDLE).
- sel  in  SEL_W  source select, sampled on accept.
- dest_reg  in  REG_ADDR_W  destination register, sampled on accept.
- src_data  in  NUM_SRC*DATA_W  flattened sources; slot i is bits [i*DATA_W +: DATA_W].
- src_valid  in  NUM_SRC  per-slot data-valid; tie high for combinational sources.
- wb_en  out  1  register-file write enable, one-cycle pulse.
- wb_addr  out  REG_ADDR_W  registered write address.
- wb_data  out  DATA_W  registered write data.
- sel_err  out  1  pulses together with the write cycle when sel was out of range, or on timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - Single clock, clk; synchronous active-high reset, reset.
  - Reset forces state=IDLE, wb_en=0, wb_addr=0, wb_data=0, sel_err=0, timeout counter=0.
  - Reset mid-operation abandons the pending request; no write occurs.
- Accept: a handshake occurs when req_valid && req_ready at a rising edge. sel and dest_reg are latched into sel_q and dest_q.
- FSM states: IDLE, WAIT, WRITE.
- IDLE:
  - On accept with sel_q resolving to CONST_SEL, or sel >= NUM_SRC: go to WRITE next edge.
    - Data is CONST_VAL (constant) or 0 (out-of-range, sets sel_err).
  - Otherwise go to WAIT.
- WAIT:
  - Each cycle, sample src_valid[sel_q].
  - When high, capture src_data slot sel_q into wb_data at that edge and go to WRITE.
  - Data is taken from the same cycle valid is seen.
- WRITE:
  - wb_en=1 for exactly this cycle, with wb_addr=dest_q.
  - wb_en is suppressed (0) when dest_q == 0, the MIPS $zero register; the state sequence is unchanged.
  - Next state is always IDLE.
- Latency:
  - Constant or out-of-range select: wb_en is high in the cycle after accept.
  - Ready source: wb_en is high 2 cycles after accept.
  - Stalled source: 2 + stall cycles after accept.
- Back-to-back: no new request is accepted during WAIT or WRITE. The earliest next accept is the cycle after WRITE, so throughput is at most one write per 2 cycles.
- Between writes: wb_addr and wb_data hold their last written values; wb_en=0; sel_err=0 except during WRITE.
- Sources: src_valid bits for unselected slots are ignored. A valid toggling on the selected slot before acceptance has no effect.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, cleared on entry.
  - If TIMEOUT cycles elapse without src_valid[sel_q], go to WRITE with wb_data=0 and sel_err=1.
  - wb_en is forced to 0 for that WRITE cycle.
- Undefined:
  - No counter; WAIT persists until valid or reset.
  - sel_err is raised only for out-of-range selects.

Decomposition:
- Package mips_wb_pkg holds:
  - state enum (IDLE/WAIT/WRITE);
  - select code constants: SEL_ALUOUT=0, SEL_LOADSIZE=1, SEL_HI=2, SEL_LO=3, SEL_SHIFTREG=4, SEL_CONST=5, SEL_SHL16=6, SEL_RT=7, SEL_SIGNEXT=8;
  - default CONST_VAL.
- One sub-module, wb_src_mux: a combinational indexed slot select with the const/out-of-range override, instantiated once inside wb_select_unit.

Test Plan:
- Reset: assert reset for 2 cycles while in WAIT with sel=2 -> state IDLE, wb_en=0, wb_addr=0, wb_data=0, req_ready=1 on release; no write seen.
- Immediate source: accept sel=0, dest=8, slot0=0xDEADBEEF, all valid -> exactly one wb_en pulse 2 cycles after accept, wb_addr=8, wb_data=0xDEADBEEF, sel_err=0.
- Stalled source: accept sel=2 (Hi), dest=9, src_valid[2] low 5 cycles then high with 0x12345678 -> wb_en 7 cycles after accept, data 0x12345678; req_ready=0 throughout.
- Constant and range:
  - sel=5, dest=3 -> wb_en in the next cycle with wb_data=277.
  - sel=12 -> wb_data=0, sel_err=1, wb_en=1.
- $zero suppression: sel=0, dest=0 -> WRITE state reached, wb_en stays 0; next request is accepted the following cycle.
- Timeout (WB_TIMEOUT_EN defined, TIMEOUT=16): sel=3 with src_valid[3] never high -> after 16 WAIT cycles, sel_err=1, wb_data=0, wb_en=0, return to IDLE.
